// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU fetch-stage types and constants
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        MISS       = 2'd2,
        MISS_REDIR = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance events
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Count one event per cycle, sticking at all-ones
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch PC/I-cache/IF-ID sequencer
module fetch_sequencer #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int PC_INC = cpu_pkg::PC_INC,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              hazard_stall_i,
    input  logic              mem_stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              icache_ready_i,
    output logic              icache_req_o,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_enable_o,
    output logic              pc_stall_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic [CNT_W-1:0]  miss_cycles_o,
    output logic [CNT_W-1:0]  redirects_o
);

    import cpu_pkg::*;

    fetch_state_e      state_d;
    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pend_pc_d;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              miss_inc;
    logic              redir_inc;

    // State and pending-redirect registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next state: a D-cache stall freezes everything; a miss remembers any redirect seen meanwhile
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (!start_i) begin
            state_d   = IDLE;
            pend_pc_d = '0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
        end else if (!mem_stall_i) begin
            if (!icache_ready_i) begin
                if (redirect_i) begin
                    state_d   = MISS_REDIR;
                    pend_pc_d = redirect_pc_i;
                end else if (state_q != MISS_REDIR) begin
                    state_d = MISS;
                end
            end else begin
                state_d = RUN;
            end
        end
    end

    // Mealy outputs: PC/IF-ID controls and counter events for this cycle
    always_comb begin
        icache_req_o = 1'b0;
        pc_next_o    = '0;
        pc_enable_o  = 1'b0;
        pc_stall_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        miss_inc     = 1'b0;
        redir_inc    = 1'b0;
        if (start_i && (state_q != IDLE)) begin
            icache_req_o = 1'b1;
            if (mem_stall_i) begin
                pc_stall_o = 1'b1;
            end else if (!icache_ready_i) begin
                pc_stall_o   = 1'b1;
                ifid_flush_o = 1'b1;
                miss_inc     = 1'b1;
                redir_inc    = redirect_i;
            end else if (state_q == MISS_REDIR) begin
                // Word fetched on the old path is dropped; jump to the latest target
                pc_enable_o  = 1'b1;
                ifid_flush_o = 1'b1;
                pc_next_o    = redirect_i ? redirect_pc_i : pend_pc_q;
                redir_inc    = redirect_i;
            end else if (redirect_i) begin
                pc_enable_o  = 1'b1;
                ifid_flush_o = 1'b1;
                pc_next_o    = redirect_pc_i;
                redir_inc    = 1'b1;
            end else if (hazard_stall_i) begin
                pc_stall_o = 1'b1;
            end else begin
                pc_enable_o  = 1'b1;
                ifid_write_o = 1'b1;
                pc_next_o    = pc_i + ADDR_W'(PC_INC);
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (miss_inc),
        .count_o (miss_cycles_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (redir_inc),
        .count_o (redirects_o)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        hazard_stall_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        icache_ready_i = 1'b0;
    logic        icache_req_o;
    logic [31:0] pc_next_o;
    logic        pc_enable_o;
    logic        pc_stall_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic [15:0] miss_cycles_o;
    logic [15:0] redirects_o;

    logic        sc_inc = 1'b0;
    logic [2:0]  sc_cnt;

    int errors = 0;
    int checks = 0;

    // reference model: running flag plus an optional pending redirect target
    bit          m_run;
    bit          m_pend_v;
    logic [31:0] m_pend;
    int          m_miss;
    int          m_redir;
    bit          e_req, e_en, e_stall, e_write, e_flush, inc_miss, inc_redir;
    logic [31:0] e_next;

    fetch_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .pc_i           (pc_i),
        .hazard_stall_i (hazard_stall_i),
        .mem_stall_i    (mem_stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .icache_ready_i (icache_ready_i),
        .icache_req_o   (icache_req_o),
        .pc_next_o      (pc_next_o),
        .pc_enable_o    (pc_enable_o),
        .pc_stall_o     (pc_stall_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .miss_cycles_o  (miss_cycles_o),
        .redirects_o    (redirects_o)
    );

    sat_counter #(.WIDTH(3)) u_sc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (sc_inc),
        .count_o (sc_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_miss   = 0;
        m_redir  = 0;
    endtask

    task automatic model_outputs();
        {e_req, e_en, e_stall, e_write, e_flush, inc_miss, inc_redir} = '0;
        e_next = '0;
        if (rst_i && start_i && m_run) begin
            e_req = 1'b1;
            if (mem_stall_i) begin
                e_stall = 1'b1;
            end else if (!icache_ready_i) begin
                e_stall   = 1'b1;
                e_flush   = 1'b1;
                inc_miss  = 1'b1;
                inc_redir = redirect_i;
            end else if (m_pend_v || redirect_i) begin
                e_en      = 1'b1;
                e_flush   = 1'b1;
                e_next    = redirect_i ? redirect_pc_i : m_pend;
                inc_redir = redirect_i;
            end else if (hazard_stall_i) begin
                e_stall = 1'b1;
            end else begin
                e_en    = 1'b1;
                e_write = 1'b1;
                e_next  = pc_i + 32'd4;
            end
        end
    endtask

    task automatic model_update();
        if (!rst_i) begin
            model_reset();
        end else begin
            if (inc_miss)  m_miss  = (m_miss  < 65535) ? m_miss + 1  : m_miss;
            if (inc_redir) m_redir = (m_redir < 65535) ? m_redir + 1 : m_redir;
            if (!start_i) begin
                m_run    = 1'b0;
                m_pend_v = 1'b0;
                m_pend   = '0;
            end else if (!m_run) begin
                m_run = 1'b1;
            end else if (!mem_stall_i) begin
                if (!icache_ready_i) begin
                    if (redirect_i) begin
                        m_pend_v = 1'b1;
                        m_pend   = redirect_pc_i;
                    end
                end else begin
                    m_pend_v = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        model_outputs();
        chk("icache_req", 32'(icache_req_o), 32'(e_req));
        chk("pc_enable", 32'(pc_enable_o), 32'(e_en));
        chk("pc_stall", 32'(pc_stall_o), 32'(e_stall));
        chk("ifid_write", 32'(ifid_write_o), 32'(e_write));
        chk("ifid_flush", 32'(ifid_flush_o), 32'(e_flush));
        chk("miss_cycles", 32'(miss_cycles_o), 32'(m_miss));
        chk("redirects", 32'(redirects_o), 32'(m_redir));
        if (e_en || !e_req) chk("pc_next", pc_next_o, e_next);
        chk("en_stall_excl", 32'(pc_enable_o & pc_stall_o), 32'd0);
    endtask

    // caller is at a negedge with inputs set; checks, clocks once, returns at next negedge
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        if (e_en) pc_i = e_next;
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        // reset state
        step();
        rst_i = 1'b1;
        start_i = 1'b1;
        icache_ready_i = 1'b1;
        step();
        // sequential fetch 0x4, 0x8, 0xC, 0x10
        for (int i = 0; i < 4; i++) step();
        chk("seq_pc", pc_i, 32'h10);
        // three-cycle miss at 0x10
        icache_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("miss_count3", 32'(miss_cycles_o), 32'd3);
        icache_ready_i = 1'b1;
        step();
        chk("after_miss_pc", pc_i, 32'h14);
        // redirect during a miss
        pc_i = 32'h20;
        icache_ready_i = 1'b0;
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        step();
        icache_ready_i = 1'b1;
        step();
        chk("miss_redir_pc", pc_i, 32'h100);
        chk("miss_redir_cnt", 32'(redirects_o), 32'd1);
        step();
        chk("run_after_redir", pc_i, 32'h104);
        // redirect beats hazard, then hazard alone
        hazard_stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        step();
        hazard_stall_i = 1'b0;
        // D-cache stall with a held redirect
        mem_stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        for (int i = 0; i < 4; i++) step();
        mem_stall_i = 1'b0;
        step();
        redirect_i = 1'b0;
        chk("mem_stall_redir_once", 32'(redirects_o), 32'd3);
        step();
        // PC wrap
        pc_i = 32'hFFFF_FFFC;
        step();
        chk("pc_wrap", pc_i, 32'h0);
        // start dropped while a redirected miss is pending
        icache_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        start_i = 1'b0;
        step();
        step();
        start_i = 1'b1;
        step();
        icache_ready_i = 1'b1;
        step();
        // randomized phase
        for (int i = 0; i < 400; i++) begin
            start_i        = ($urandom_range(0, 31) != 0);
            hazard_stall_i = ($urandom_range(0, 3) == 0);
            mem_stall_i    = ($urandom_range(0, 5) == 0);
            redirect_i     = ($urandom_range(0, 4) == 0);
            redirect_pc_i  = {$urandom()} & 32'hFFFF_FFFC;
            icache_ready_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) pc_i = {$urandom()} & 32'hFFFF_FFFC;
            step();
        end
        // saturating counter boundary on a narrow instance
        for (int i = 0; i < 10; i++) begin
            sc_inc = 1'b1;
            @(negedge clk_i);
        end
        sc_inc = 1'b0;
        chk("sat_counter_max", 32'(sc_cnt), 32'd7);
        // async reset in the middle of a miss
        start_i = 1'b1;
        mem_stall_i = 1'b0;
        redirect_i = 1'b0;
        icache_ready_i = 1'b0;
        step();
        step();
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        chk("rst_miss_cnt", 32'(miss_cycles_o), 32'd0);
        chk("rst_redir_cnt", 32'(redirects_o), 32'd0);
        chk("rst_req", 32'(icache_req_o), 32'd0);
        chk("rst_flush", 32'(ifid_flush_o), 32'd0);
        @(negedge clk_i);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
